// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache fill paths, the unified memory port and
// the memory arbiter. The arbiter connects through the slave modport; the
// environment (caches and memory) uses the master modport.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // I-cache side
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_pause;
    logic              i_data_vld;
    // D-cache side
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_pause;
    logic              d_data_vld;
    logic              d_wr_done;
    // Shared read data and memory port
    logic [DATA_W-1:0] rd_data;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_vld;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_vld,
        output i_pause, i_data_vld, d_pause, d_data_vld, d_wr_done, rd_data,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_vld,
        input  i_pause, i_data_vld, d_pause, d_data_vld, d_wr_done, rd_data,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Unified-memory arbiter between I-cache and D-cache.
// Grants one requester for a whole block fill or a single write-through word,
// pauses the loser, routes data-valid to the owner only, and breaks ties by
// round-robin (last-grant bit lg; I-cache wins the first tie after reset).
// Optional build macro MEM_ARB_PERF_CNT_EN adds saturating grant and stall
// counters on extra output ports.
module mem_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [15:0]   perf_i_grants,
    output logic [15:0]   perf_d_grants,
    output logic [15:0]   perf_stall_cycles
`endif
);

    localparam int CNT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam logic [CNT_W-1:0] LAST_VLD = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             lg_q, lg_d;

    // Next-state: arbitration in IDLE, valid counting while a fill owns the port
    always_comb begin
        state_d = state_q;
        vcnt_d  = vcnt_q;
        lg_d    = lg_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req && (!bus.d_req || lg_q)) begin
                    state_d = I_FILL;
                    lg_d    = 1'b0;
                end else if (bus.d_req) begin
                    state_d = bus.d_wr ? D_WRITE : D_FILL;
                    lg_d    = 1'b1;
                end
            end
            // A fill is held until every word has come back, even if the
            // owner has dropped its request in the meantime.
            I_FILL, D_FILL: begin
                if (bus.mem_data_vld) begin
                    if (vcnt_q == LAST_VLD) begin
                        vcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end
            end
            D_WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, valid counter and last-grant registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            vcnt_q  <= '0;
            lg_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
            lg_q    <= lg_d;
        end
    end

    // Output decode: pauses, data-valid routing and the memory port mux.
    // Pauses are gated by reset so every output is quiet while rst is low.
    always_comb begin
        bus.rd_data    = bus.mem_rdata;
        bus.i_pause    = rst & bus.i_req & (state_q != I_FILL);
        bus.d_pause    = rst & bus.d_req & (state_q != D_FILL) & (state_q != D_WRITE);
        bus.i_data_vld = bus.mem_data_vld & (state_q == I_FILL);
        bus.d_data_vld = bus.mem_data_vld & (state_q == D_FILL);
        bus.d_wr_done  = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = {ADDR_W{1'b0}};
        bus.mem_wdata  = {DATA_W{1'b0}};
        case (state_q)
            I_FILL: begin
                bus.mem_en = bus.i_req;
                if (bus.i_req) bus.mem_addr = bus.i_addr;
            end
            D_FILL: begin
                bus.mem_en = bus.d_req;
                if (bus.d_req) bus.mem_addr = bus.d_addr;
            end
            D_WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.d_wr_done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] pig_q, pdg_q, psc_q;
    logic        grant_i, grant_d, stall;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign grant_i = (state_q == IDLE) && (state_d == I_FILL);
    assign grant_d = (state_q == IDLE) && ((state_d == D_FILL) || (state_d == D_WRITE));
    assign stall   = bus.i_pause | bus.d_pause;

    // Saturating grant and stall counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pig_q <= '0;
            pdg_q <= '0;
            psc_q <= '0;
        end else begin
            if (grant_i) pig_q <= sat_inc(pig_q);
            if (grant_d) pdg_q <= sat_inc(pdg_q);
            if (stall)   psc_q <= sat_inc(psc_q);
        end
    end

    assign perf_i_grants     = pig_q;
    assign perf_d_grants     = pdg_q;
    assign perf_stall_cycles = psc_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a directed vector table, hand-written multi-cycle
// sequences (request dropped mid-fill, reset mid-fill) and randomized traffic,
// all compared against an ownership-based reference model.
module tb_mem_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int WPB = 8;

    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;
    localparam int OWN_WR   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] pig, pdg, psc;
`endif

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_i_grants     (pig),
        .perf_d_grants     (pdg),
        .perf_stall_cycles (psc)
`endif
    );

    typedef struct packed {
        logic        rn;
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dwd;
        logic        mv;
        logic [15:0] mr;
    } stim_t;

    typedef struct packed {
        logic        ip;
        logic        dp;
        logic        iv;
        logic        dv;
        logic        wd;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } resp_t;

    typedef struct {
        stim_t s;
        resp_t e;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the port, how many words are still owed,
    // and who was served last.
    int m_owner;
    int m_left;
    bit m_last_d;
    int m_gi, m_gd, m_st;

    function automatic stim_t S(input logic rn, ir, dr, dw, input logic [15:0] da, dwd,
                                input logic mv);
        stim_t s;
        s.rn  = rn;
        s.ir  = ir;
        s.ia  = 16'h0100;
        s.dr  = dr;
        s.dw  = dw;
        s.da  = da;
        s.dwd = dwd;
        s.mv  = mv;
        s.mr  = 16'h5A00 ^ da;
        return s;
    endfunction

    function automatic resp_t R(input logic ip, dp, iv, dv, wd, en, wr,
                                input logic [15:0] addr, wdata);
        resp_t r;
        r.ip = ip; r.dp = dp; r.iv = iv; r.dv = dv; r.wd = wd;
        r.en = en; r.wr = wr; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    task automatic model_reset();
        m_owner  = OWN_NONE;
        m_left   = 0;
        m_last_d = 1'b1;
        m_gi = 0; m_gd = 0; m_st = 0;
    endtask

    function automatic resp_t model_out(input stim_t s);
        resp_t r = '0;
        if (!s.rn) return r;
        r.ip = s.ir && (m_owner != OWN_I);
        r.dp = s.dr && (m_owner != OWN_D) && (m_owner != OWN_WR);
        r.iv = s.mv && (m_owner == OWN_I);
        r.dv = s.mv && (m_owner == OWN_D);
        if (m_owner == OWN_I) begin
            r.en   = s.ir;
            r.addr = s.ir ? s.ia : 16'h0;
        end else if (m_owner == OWN_D) begin
            r.en   = s.dr;
            r.addr = s.dr ? s.da : 16'h0;
        end else if (m_owner == OWN_WR) begin
            r.en = 1'b1; r.wr = 1'b1; r.wd = 1'b1;
            r.addr = s.da; r.wdata = s.dwd;
        end
        return r;
    endfunction

    task automatic model_step(input stim_t s);
        resp_t r;
        if (!s.rn) begin
            model_reset();
            return;
        end
        r = model_out(s);
        if ((r.ip || r.dp) && m_st < 65535) m_st++;
        if (m_owner == OWN_NONE) begin
            if (s.ir && (!s.dr || m_last_d)) begin
                m_owner = OWN_I; m_left = WPB; m_last_d = 1'b0;
                if (m_gi < 65535) m_gi++;
            end else if (s.dr) begin
                m_owner = s.dw ? OWN_WR : OWN_D; m_left = WPB; m_last_d = 1'b1;
                if (m_gd < 65535) m_gd++;
            end
        end else if (m_owner == OWN_WR) begin
            m_owner = OWN_NONE;
        end else if (s.mv) begin
            m_left--;
            if (m_left == 0) m_owner = OWN_NONE;
        end
    endtask

    task automatic apply(input stim_t s);
        rst              = s.rn;
        bus.i_req        = s.ir;
        bus.i_addr       = s.ia;
        bus.d_req        = s.dr;
        bus.d_wr         = s.dw;
        bus.d_addr       = s.da;
        bus.d_wdata      = s.dwd;
        bus.mem_data_vld = s.mv;
        bus.mem_rdata    = s.mr;
    endtask

    function automatic resp_t dut_out();
        return R(bus.i_pause, bus.d_pause, bus.i_data_vld, bus.d_data_vld, bus.d_wr_done,
                 bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
    endfunction

    task automatic check_resp(input string nm, input resp_t got, input resp_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got{ip,dp,iv,dv,wd,en,wr,addr,wdata}=%b%b%b%b%b%b%b,%h,%h required=%b%b%b%b%b%b%b,%h,%h",
                     nm, got.ip, got.dp, got.iv, got.dv, got.wd, got.en, got.wr, got.addr, got.wdata,
                     exp.ip, exp.dp, exp.iv, exp.dv, exp.wd, exp.en, exp.wr, exp.addr, exp.wdata);
        end
    endtask

    // One cycle: drive after the falling edge, compare, then clock the model.
    task automatic run_cycle(input stim_t s, input string nm, input bit has_exp, input resp_t exp);
        apply(s);
        #1;
        check_resp({nm, "/model"}, dut_out(), model_out(s));
        if (has_exp) check_resp({nm, "/vec"}, dut_out(), exp);
        checks++;
        if (bus.rd_data !== s.mr) begin
            failures++;
            $display("FAIL %s/rd_data got=%h required=%h", nm, bus.rd_data, s.mr);
        end
        @(posedge clk);
        model_step(s);
        @(negedge clk);
    endtask

    vec_t tbl[$];
    stim_t st;
    logic ir_r, dr_r;

    initial begin
        model_reset();
        apply(S(0, 0, 0, 0, 16'h0, 16'h0, 0));
        @(negedge clk);

        // Directed vector table
        tbl.push_back('{S(0,1,0,0,16'h0000,16'h0000,0), R(0,0,0,0,0,0,0,16'h0000,16'h0000)});
        tbl.push_back('{S(1,1,0,0,16'h0000,16'h0000,0), R(1,0,0,0,0,0,0,16'h0000,16'h0000)});
        tbl.push_back('{S(1,1,1,0,16'h3000,16'h0000,0), R(0,1,0,0,0,1,0,16'h0100,16'h0000)});
        for (int k = 0; k < WPB; k++)
            tbl.push_back('{S(1,1,1,0,16'h3000,16'h0000,1), R(0,1,1,0,0,1,0,16'h0100,16'h0000)});
        tbl.push_back('{S(1,1,1,0,16'h3000,16'h0000,0), R(1,1,0,0,0,0,0,16'h0000,16'h0000)});
        tbl.push_back('{S(1,1,1,0,16'h3000,16'h0000,0), R(1,0,0,0,0,1,0,16'h3000,16'h0000)});
        for (int k = 0; k < WPB; k++)
            tbl.push_back('{S(1,1,1,0,16'h3000,16'h0000,1), R(1,0,0,1,0,1,0,16'h3000,16'h0000)});
        tbl.push_back('{S(1,0,1,1,16'h2A40,16'hBEEF,0), R(0,1,0,0,0,0,0,16'h0000,16'h0000)});
        tbl.push_back('{S(1,0,1,1,16'h2A40,16'hBEEF,1), R(0,0,0,0,1,1,1,16'h2A40,16'hBEEF)});
        tbl.push_back('{S(1,0,0,0,16'h0000,16'h0000,1), R(0,0,0,0,0,0,0,16'h0000,16'h0000)});
        for (int k = 0; k < tbl.size(); k++)
            run_cycle(tbl[k].s, $sformatf("vec%0d", k), 1'b1, tbl[k].e);

        // I-cache drops its request after 3 valids; pending D read waits
        run_cycle(S(1,1,0,0,16'h4444,16'h0,0), "drop_grant", 1'b1, R(1,0,0,0,0,0,0,16'h0,16'h0));
        for (int k = 0; k < 3; k++)
            run_cycle(S(1,1,1,0,16'h4444,16'h0,1), $sformatf("drop_v%0d", k), 1'b1,
                      R(0,1,1,0,0,1,0,16'h0100,16'h0));
        run_cycle(S(1,0,1,0,16'h4444,16'h0,0), "drop_gap", 1'b1, R(0,1,0,0,0,0,0,16'h0,16'h0));
        for (int k = 3; k < WPB; k++)
            run_cycle(S(1,0,1,0,16'h4444,16'h0,1), $sformatf("drop_v%0d", k), 1'b1,
                      R(0,1,1,0,0,0,0,16'h0,16'h0));
        run_cycle(S(1,0,1,0,16'h4444,16'h0,0), "drop_idle", 1'b1, R(0,1,0,0,0,0,0,16'h0,16'h0));
        run_cycle(S(1,0,1,0,16'h4444,16'h0,1), "dfill_v0", 1'b1, R(0,0,0,1,0,1,0,16'h4444,16'h0));

        // Reset in the middle of a D fill once 5 words have arrived
        for (int k = 1; k < 5; k++)
            run_cycle(S(1,0,1,0,16'h4444,16'h0,1), $sformatf("dfill_v%0d", k), 1'b1,
                      R(0,0,0,1,0,1,0,16'h4444,16'h0));
        run_cycle(S(0,0,1,0,16'h4444,16'h0,1), "mid_rst", 1'b1, R(0,0,0,0,0,0,0,16'h0,16'h0));
        run_cycle(S(1,0,1,0,16'h4444,16'h0,0), "rst_idle", 1'b1, R(0,1,0,0,0,0,0,16'h0,16'h0));
        for (int k = 0; k < WPB - 1; k++)
            run_cycle(S(1,0,1,0,16'h4444,16'h0,1), $sformatf("refill_v%0d", k), 1'b1,
                      R(0,0,0,1,0,1,0,16'h4444,16'h0));
        run_cycle(S(1,0,1,0,16'h4444,16'h0,0), "refill_hold", 1'b1, R(0,0,0,0,0,1,0,16'h4444,16'h0));
        run_cycle(S(1,0,1,0,16'h4444,16'h0,1), "refill_last", 1'b1, R(0,0,0,1,0,1,0,16'h4444,16'h0));
        run_cycle(S(1,0,0,0,16'h4444,16'h0,0), "refill_done", 1'b1, R(0,0,0,0,0,0,0,16'h0,16'h0));

        // Randomized traffic against the model
        ir_r = 1'b0;
        dr_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) ir_r = ~ir_r;
            if ($urandom_range(0, 3) == 0) dr_r = ~dr_r;
            st.rn  = ($urandom_range(0, 299) != 0);
            st.ir  = ir_r;
            st.ia  = 16'($urandom);
            st.dr  = dr_r;
            st.dw  = ($urandom_range(0, 2) == 0);
            st.da  = 16'($urandom);
            st.dwd = 16'($urandom);
            st.mv  = $urandom_range(0, 1) == 1;
            st.mr  = 16'($urandom);
            run_cycle(st, $sformatf("rnd%0d", n), 1'b0, '0);
        end

`ifdef MEM_ARB_PERF_CNT_EN
        checks++;
        if (pig !== 16'(m_gi) || pdg !== 16'(m_gd) || psc !== 16'(m_st)) begin
            failures++;
            $display("FAIL perf got=%0d/%0d/%0d required=%0d/%0d/%0d", pig, pdg, psc, m_gi, m_gd, m_st);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared unified-memory port between the I-cache and D-cache refill/write paths.
- Each cache's fill FSM issues per-word addresses. The arbiter grants one requester for a whole 8-word block fill or a single write-through word.
- It pauses the losing cache, routes data-valid only to the owner, and resolves ties by round-robin.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- WORDS_PER_BLOCK, 8, memory words returned per block fill (power of 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache read request (fill FSM read_request).
- i_addr  in  ADDR_W  I-cache word address for the current cycle.
- i_pause  out  1  stall to the I-cache fill FSM.
- i_data_vld  out  1  memory data valid, routed to the I-cache.
- d_req  in  1  D-cache request.
- d_wr  in  1  D-cache request is a write-through word (qualifies d_req).
- d_addr  in  ADDR_W  D-cache word address.
- d_wdata  in  DATA_W  D-cache write data.
- d_pause  out  1  stall to the D-cache fill FSM.
- d_data_vld  out  1  memory data valid, routed to the D-cache.
- d_wr_done  out  1  one-cycle pulse when the write has been issued.
- rd_data  out  DATA_W  mem_rdata broadcast to both caches.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_data_vld  in  1  memory read data valid.

Behaviour:
- States: IDLE, I_FILL, D_FILL, D_WRITE.
  - Registered state, 3-bit valid counter vcnt, and last-grant bit lg (0 = I served last, 1 = D served last).
- Reset (rst=0, asynchronous):
  - state=IDLE, vcnt=0, lg=1 so the I-cache wins the first tie.
  - All outputs 0 except rd_data, which is a combinational passthrough of mem_rdata.
- IDLE:
  - Only i_req → I_FILL, lg←0.
  - Only d_req → D_WRITE if d_wr, else D_FILL; lg←1.
  - Both requesting → grant the requester opposite lg.
  - Neither → stay in IDLE.
  - mem_en=0 while in IDLE. The first memory access occurs the cycle after the request is seen, a 1-cycle arbitration latency.
- Pause and data-valid routing (combinational):
  - i_pause = i_req & (state != I_FILL).
  - d_pause = d_req & (state not in {D_FILL, D_WRITE}).
  - i_data_vld = mem_data_vld & (state == I_FILL).
  - d_data_vld = mem_data_vld & (state == D_FILL).
- I_FILL / D_FILL:
  - mem_en = owner's req, mem_wr = 0, mem_addr = owner's addr.
  - vcnt increments on each mem_data_vld.
  - On mem_data_vld with vcnt == WORDS_PER_BLOCK-1: vcnt←0 and state←IDLE.
  - If the owner drops req before the last valid, the state is held until all valids drain; no new grant is issued mid-fill.
- D_WRITE:
  - mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata for exactly one cycle.
  - d_wr_done=1 in that cycle; next state IDLE.
- mem_wdata is 0 outside D_WRITE. mem_addr is 0 when mem_en=0.
- A request arriving during another owner's transaction is held off by its pause and is serviced in the first IDLE cycle after that transaction ends.
- Back-to-back transactions always pass through one IDLE cycle.
- Stray mem_data_vld in IDLE or D_WRITE: ignored, not routed, vcnt unchanged.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, the block adds:
  - Outputs perf_i_grants[15:0] and perf_d_grants[15:0]: incremented on each transition out of IDLE to that requester.
  - Output perf_stall_cycles[15:0]: incremented each cycle where i_pause | d_pause.
  - All counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset with i_req=1: all outputs 0. After rst rises, the next edge enters I_FILL and mem_en=1, mem_addr=i_addr=16'h0100.
- I-fill alone, memory returning 8 valids: i_data_vld pulses exactly 8 times, d_data_vld stays 0, state returns to IDLE after the 8th.
- i_req and d_req (read) asserted in the same cycle from reset: I granted first with d_pause=1 throughout. D_FILL follows after one IDLE cycle. Repeating the simultaneous request grants D first (round-robin).
- D write d_addr=16'h2A40, d_wdata=16'hBEEF: one cycle with mem_en=1, mem_wr=1, mem_addr=16'h2A40, mem_wdata=16'hBEEF, d_wr_done=1.
- i_req dropped after 3 valids: arbiter stays in I_FILL until 8 valids. A pending d_req is granted only after that.
- rst pulsed mid D_FILL at vcnt=5: immediately IDLE with all outputs 0. The next fill requires a full 8 valids.
